// File: rtl/req_source_pkg.sv
// Shared state encoding and default parameter values for the req_source burst generator.
// The ERR state exists only when REQ_SOURCE_TIMEOUT_EN is defined.
package req_source_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_NUM_REQ = 16;
    localparam int DEF_TIMEOUT = 8;
    localparam int STALL_W     = 16;

`ifdef REQ_SOURCE_TIMEOUT_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_e;
`endif

endpackage

// File: rtl/sat_counter.sv
// Up-counter that clears on demand and sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/req_source.sv
// Burst source: on start, offers NUM_REQ incrementing beats on a valid/ready port.
// Define REQ_SOURCE_TIMEOUT_EN to abort into ERR after TIMEOUT consecutive stall cycles.
module req_source
    import req_source_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [DATA_W-1:0]            start_data,
    output logic                         valid,
    input  logic                         ready,
    output logic [DATA_W-1:0]            data,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NUM_REQ+1)-1:0] sent_count,
`ifdef REQ_SOURCE_TIMEOUT_EN
    output logic                         timeout,
`endif
    output logic [STALL_W-1:0]           stall_cycles
);

    localparam int SC_W = $clog2(NUM_REQ + 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SC_W-1:0]   sent_count_q, sent_count_d;
    logic              start_ok;
    logic              handshake;
    logic              stalling;
    logic              last_beat;

    assign valid     = (state_q == S_SEND);
    assign busy      = (state_q == S_SEND);
    assign done      = (state_q == S_DONE);
    assign handshake = valid && ready;
    assign stalling  = valid && !ready;
    assign last_beat = (sent_count_q == SC_W'(NUM_REQ - 1));

`ifdef REQ_SOURCE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] consec_stall;
    logic            timeout_hit;
    logic            timeout_q, timeout_d;

    // This stall cycle is the TIMEOUT-th in a row, so the burst aborts at this edge.
    assign timeout_hit = stalling && (consec_stall == TO_W'(TIMEOUT - 1));

    sat_counter #(.WIDTH(TO_W)) u_consec_cnt (
        .clock (clock),
        .reset (reset),
        .clear (start_ok || handshake),
        .inc   (stalling),
        .count (consec_stall)
    );

    always_comb begin
        timeout_d = timeout_q;
        if (start_ok) begin
            timeout_d = 1'b0;
        end else if (timeout_hit) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`endif

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        sent_count_d = sent_count_q;
        start_ok     = 1'b0;
        case (state_q)
            S_IDLE: start_ok = start;
            S_SEND: begin
                if (handshake) begin
                    data_d       = data_q + DATA_W'(1);
                    sent_count_d = sent_count_q + SC_W'(1);
                    if (last_beat) begin
                        state_d = S_DONE;
                    end
                end
`ifdef REQ_SOURCE_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_d = S_ERR;
                end
`endif
            end
            S_DONE: state_d = S_IDLE;
`ifdef REQ_SOURCE_TIMEOUT_EN
            S_ERR:  start_ok = start;
`endif
            default: state_d = S_IDLE;
        endcase
        // A fresh burst overrides everything above; only reachable from IDLE/ERR.
        if (start_ok) begin
            state_d      = S_SEND;
            data_d       = start_data;
            sent_count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            data_q       <= '0;
            sent_count_q <= '0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            sent_count_q <= sent_count_d;
        end
    end

    sat_counter #(.WIDTH(STALL_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .clear (start_ok),
        .inc   (stalling),
        .count (stall_cycles)
    );

    assign data       = data_q;
    assign sent_count = sent_count_q;

endmodule

// File: tb/tb_req_source.sv
// Directed bench for req_source: a 16-beat instance and a 4-beat wrap-around instance.
// Timeout abort is exercised when REQ_SOURCE_TIMEOUT_EN is defined.
module tb_req_source;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        start = 1'b0;
    logic [31:0] start_data = '0;
    logic        ready = 1'b0;
    logic        valid;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic [4:0]  sent_count;
    logic [15:0] stall_cycles;

    logic        s_start = 1'b0;
    logic [31:0] s_start_data = '0;
    logic        s_ready = 1'b0;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_busy;
    logic        s_done;
    logic [2:0]  s_sent_count;
    logic [15:0] s_stall_cycles;

`ifdef REQ_SOURCE_TIMEOUT_EN
    logic        timeout;
    logic        s_timeout;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    req_source #(.DATA_W(32), .NUM_REQ(16), .TIMEOUT(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .start_data   (start_data),
        .valid        (valid),
        .ready        (ready),
        .data         (data),
        .busy         (busy),
        .done         (done),
        .sent_count   (sent_count),
`ifdef REQ_SOURCE_TIMEOUT_EN
        .timeout      (timeout),
`endif
        .stall_cycles (stall_cycles)
    );

    req_source #(.DATA_W(32), .NUM_REQ(4), .TIMEOUT(8)) dut_small (
        .clock        (clock),
        .reset        (reset),
        .start        (s_start),
        .start_data   (s_start_data),
        .valid        (s_valid),
        .ready        (s_ready),
        .data         (s_data),
        .busy         (s_busy),
        .done         (s_done),
        .sent_count   (s_sent_count),
`ifdef REQ_SOURCE_TIMEOUT_EN
        .timeout      (s_timeout),
`endif
        .stall_cycles (s_stall_cycles)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs set here apply to the next edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] exp4 [4];
        exp4[0] = 32'hFFFF_FFFE;
        exp4[1] = 32'hFFFF_FFFF;
        exp4[2] = 32'h0000_0000;
        exp4[3] = 32'h0000_0001;

        // Reset state
        step();
        step();
        check_val("rst_valid", 32'(valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_data", data, 32'd0);
        check_val("rst_sent", 32'(sent_count), 32'd0);
        check_val("rst_stall", 32'(stall_cycles), 32'd0);
        reset = 1'b0;

        // Full burst with ready held high
        ready = 1'b1;
        start = 1'b1;
        start_data = 32'h100;
        step();
        start = 1'b0;
        for (int b = 0; b < 16; b++) begin
            check_val($sformatf("t1_valid%0d", b), 32'(valid), 32'd1);
            check_val($sformatf("t1_data%0d", b), data, 32'(32'h100 + b));
            step();
        end
        check_val("t1_done", 32'(done), 32'd1);
        check_val("t1_valid_off", 32'(valid), 32'd0);
        check_val("t1_sent", 32'(sent_count), 32'd16);
        check_val("t1_stall", 32'(stall_cycles), 32'd0);
        step();
        step();
        check_val("t1_idle_done", 32'(done), 32'd0);
        check_val("t1_idle_busy", 32'(busy), 32'd0);
        check_val("t1_hold_data", data, 32'h110);
        check_val("t1_hold_sent", 32'(sent_count), 32'd16);

        // Stall on beat 0x105 for three cycles; a start mid-burst must be ignored
        start = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < 16; b++) begin
            check_val($sformatf("t2_data%0d", b), data, 32'(32'h100 + b));
            check_val($sformatf("t2_sent%0d", b), 32'(sent_count), 32'(b));
            if (b == 8) begin
                start = 1'b1;
                start_data = 32'h999;
            end else begin
                start = 1'b0;
            end
            if (b == 5) begin
                ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    check_val($sformatf("t2_held%0d", k), data, 32'h105);
                    check_val($sformatf("t2_hvalid%0d", k), 32'(valid), 32'd1);
                end
                ready = 1'b1;
            end
            step();
        end
        start = 1'b0;
        start_data = 32'h100;
        check_val("t2_done", 32'(done), 32'd1);
        check_val("t2_sent", 32'(sent_count), 32'd16);
        check_val("t2_stall", 32'(stall_cycles), 32'd3);
        step();

        // Reset at beat 7, then reset priority over start
        start = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < 7; b++) step();
        check_val("t3_sent7", 32'(sent_count), 32'd7);
        check_val("t3_data7", data, 32'h107);
        reset = 1'b1;
        step();
        check_val("t3_valid", 32'(valid), 32'd0);
        check_val("t3_sent", 32'(sent_count), 32'd0);
        check_val("t3_data", data, 32'd0);
        start = 1'b1;
        step();
        check_val("t3_prio_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        step();

        // Four-beat burst wrapping through 2^32
        s_ready = 1'b1;
        s_start = 1'b1;
        s_start_data = 32'hFFFF_FFFE;
        step();
        s_start = 1'b0;
        for (int b = 0; b < 4; b++) begin
            check_val($sformatf("t4_valid%0d", b), 32'(s_valid), 32'd1);
            check_val($sformatf("t4_data%0d", b), s_data, exp4[b]);
            step();
        end
        check_val("t4_done", 32'(s_done), 32'd1);
        check_val("t4_sent", 32'(s_sent_count), 32'd4);

`ifdef REQ_SOURCE_TIMEOUT_EN
        // Two beats accepted, then stall until the burst aborts
        ready = 1'b1;
        start = 1'b1;
        start_data = 32'h200;
        step();
        start = 1'b0;
        check_val("t5_data0", data, 32'h200);
        step();
        check_val("t5_data1", data, 32'h201);
        step();
        ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_val($sformatf("t5_stall_valid%0d", k), 32'(valid), 32'd1);
            check_val($sformatf("t5_stall_data%0d", k), data, 32'h202);
            step();
        end
        check_val("t5_timeout", 32'(timeout), 32'd1);
        check_val("t5_valid", 32'(valid), 32'd0);
        check_val("t5_busy", 32'(busy), 32'd0);
        check_val("t5_sent", 32'(sent_count), 32'd2);
        check_val("t5_stall", 32'(stall_cycles), 32'd8);
        ready = 1'b1;
        step();
        check_val("t5_err_hold", 32'(timeout), 32'd1);
        check_val("t5_err_valid", 32'(valid), 32'd0);
        start = 1'b1;
        start_data = 32'h300;
        step();
        start = 1'b0;
        check_val("t5_restart_to", 32'(timeout), 32'd0);
        check_val("t5_restart_valid", 32'(valid), 32'd1);
        check_val("t5_restart_data", data, 32'h300);
        check_val("t5_restart_sent", 32'(sent_count), 32'd0);
`else
        // Without the abort feature a long stall just keeps waiting
        ready = 1'b0;
        start = 1'b1;
        start_data = 32'h200;
        step();
        start = 1'b0;
        for (int k = 0; k < 20; k++) step();
        check_val("t5_wait_valid", 32'(valid), 32'd1);
        check_val("t5_wait_data", data, 32'h200);
        check_val("t5_wait_stall", 32'(stall_cycles), 32'd20);
        ready = 1'b1;
        step();
        check_val("t5_resume_data", data, 32'h201);
        check_val("t5_resume_sent", 32'(sent_count), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/req_source.md
REQ_SOURCE -- requirements
Module: req_source

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 16, number of beats per burst (>=1).
REQ-003 SHALL have parameter TIMEOUT, default 8, consecutive stall cycles before abort (>=1).
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  burst request pulse.
REQ-007 SHALL have port start_data  input  DATA_W  first-beat payload, sampled with start.
REQ-008 SHALL have port valid  output  1  beat offered downstream.
REQ-009 SHALL have port ready  input  1  downstream accepts beat.
REQ-010 SHALL have port data  output  DATA_W  beat payload.
REQ-011 SHALL have port busy  output  1  high in SEND state.
REQ-012 SHALL have port done  output  1  one-cycle burst-complete pulse.
REQ-013 SHALL have port sent_count  output  $clog2(NUM_REQ+1)  beats accepted in current/last burst.
REQ-014 SHALL have port stall_cycles  output  16  cycles with valid=1, ready=0 in current/last burst, saturating at 0xFFFF.
REQ-015 SHALL have port timeout  output  1  sticky abort flag (present only when REQ_SOURCE_TIMEOUT_EN defined).

Function
REQ-016 SHALL implement states IDLE, SEND, DONE, and ERR (ERR only with macro).
REQ-017 In IDLE, start=1 SHALL latch start_data into data, clear sent_count, stall_cycles and timeout, and move to SEND; valid rises the following cycle.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 In SEND, valid SHALL be 1; a handshake is valid&&ready in the same cycle.
REQ-020 On handshake, sent_count SHALL increment and data SHALL become data+1 modulo 2^DATA_W, presented next cycle (back-to-back beats allowed, no bubble).
REQ-021 While valid=1 and ready=0, data and valid SHALL hold unchanged and stall_cycles SHALL increment (saturating).
REQ-022 Handshake of beat NUM_REQ SHALL move to DONE; valid=0 from the next cycle.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE; done=0 in all other states.
REQ-024 sent_count, stall_cycles and data SHALL hold their values in IDLE until the next accepted start.
REQ-025 ready SHALL be ignored when valid=0.

Reset
REQ-026 reset SHALL force state IDLE, valid=0, busy=0, done=0, data=0, sent_count=0, stall_cycles=0, timeout=0 at the next clock edge, including mid-burst; reset has priority over start.

Configuration
REQ-027 With REQ_SOURCE_TIMEOUT_EN defined, a consecutive-stall counter SHALL clear on any handshake; reaching TIMEOUT SHALL move to ERR, drop valid the next cycle and set timeout=1.
REQ-028 ERR SHALL hold valid=0, busy=0; only start (returns to SEND with fresh burst) or reset leaves it; timeout stays 1 until then.
REQ-029 Without the macro, the timeout port, ERR state and consecutive-stall counter SHALL be absent; SEND waits indefinitely for ready.

Structure
REQ-030 Package req_source_pkg SHALL hold the state enum and default parameter constants.
REQ-031 One sub-module, sat_counter (parameterised width, clear, increment, saturate), SHALL implement stall_cycles and the timeout counter.

Verification
REQ-032 ready=1 constant, start, start_data=0x100 -> valid on cycles 1..16 with data 0x100..0x10F, done at cycle 17, sent_count=16, stall_cycles=0.
REQ-033 ready=0 for 3 cycles when beat 0x105 offered -> 0x105 held 4 cycles, final stall_cycles=3, sent_count=16.
REQ-034 start_data=0xFFFFFFFE, NUM_REQ=4 -> beats 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-035 Macro on, TIMEOUT=8, ready=1 for 2 beats then 0 -> after 8 stall cycles timeout=1, valid=0, sent_count=2; next start clears timeout, burst restarts.
REQ-036 reset asserted at beat 7 of SEND -> next cycle valid=0, sent_count=0, data=0; start during SEND ignored (sent_count continues 1..16 uninterrupted).
